ps2_host_tx: RTL
================

// Module: ps2_host_tx
// PURPOSE
//  PS/2 host-to-device transmitter: sends one command byte (e.g. 0xED set-LEDs, 0xFF reset) to the keyboard.
//  It is the opposite direction to the keyboard receive path and shares the same ps2c/ps2d lines.
//  Lines are open-drain: this block only drives them low, through the *_oe_o enables; the pad releases on 0.
//  tx_idle_o gates the keyboard receiver so it ignores traffic while this block owns the bus.
// PARAMETERS
//  INHIBIT_CYCLES  5000       clk_i cycles ps2c is held low before the start bit (100 us at 50 MHz)
//  FILTER_LEN      8          ps2c glitch-filter length in samples (2..16)
//  TIMEOUT_CYCLES  1_000_000  max clk_i cycles between device clock falls before abort (20 ms at 50 MHz)
// PORTS
//  clk_i           in   1  system clock
//  rst_i           in   1  synchronous reset, active-high
//  wr_ps2_i        in   1  1-cycle strobe: start transmitting din_i (only accepted in IDLE)
//  din_i           in   8  command byte, sampled when the strobe is accepted
//  ps2c_i          in   1  PS/2 clock line as read back from the pad
//  ps2d_i          in   1  PS/2 data line as read back from the pad
//  ps2c_oe_o       out  1  1 = pull ps2c low; registered
//  ps2d_oe_o       out  1  1 = pull ps2d low; registered
//  tx_idle_o       out  1  1 = FSM in IDLE; registered
//  tx_done_tick_o  out  1  1-cycle pulse: frame ended with a valid device ACK
//  err_tick_o      out  1  1-cycle pulse: frame aborted (no ACK or timeout)
// BEHAVIOUR
//  Reset: state=IDLE; ps2c_oe_o=0, ps2d_oe_o=0, tx_idle_o=1, both ticks=0; filter set to all ones; counters=0.
//  Reset mid-frame: both lines are released at the first clock edge with rst_i high. No tick is generated.
//  Clock filter: ps2c_i is shifted into a FILTER_LEN shift register.
//   The filtered clock goes to 1 when all bits are 1, goes to 0 when all bits are 0, and otherwise holds.
//   fall = filtered clock was 1 last cycle and is 0 this cycle; it is a 1-cycle pulse.
//  Frame register: {parity, din_i} (9 bits) is loaded on accept; parity = ~^din_i (odd parity).
//  FSM:
//   IDLE: if wr_ps2_i, load frame and go to RTS; tx_idle_o drops on the next cycle. Otherwise stay.
//   RTS: ps2c_oe_o=1 for exactly INHIBIT_CYCLES cycles, then go to REQ.
//   REQ: ps2c_oe_o=1 and ps2d_oe_o=1 for 1 cycle, then go to DATA.
//    ps2c is released at this point; ps2d stays low as the start bit.
//   DATA: ps2c_oe_o=0. Each fall shifts out the next frame bit, LSB first, with ps2d_oe_o = ~bit.
//    The shifts run data[0] .. data[7], then parity, on falls 1..9.
//    On fall 10, release ps2d (stop bit) and go to ACK.
//   ACK: on the next fall (fall 11), sample ps2d_i.
//    If it is 0 (ACK), go to WREL with ack_ok set. If it is 1 (no ACK), go to WREL with ack_ok clear.
//   WREL: wait until the filtered clock = 1 and ps2d_i = 1, then go to IDLE.
//    On that cycle pulse tx_done_tick_o if ack_ok, else pulse err_tick_o.
//  Timeout: a counter is cleared on entering DATA and on every fall, and increments otherwise in DATA/ACK/WREL.
//   When it reaches TIMEOUT_CYCLES: release both lines, pulse err_tick_o, go to IDLE.
//  wr_ps2_i outside IDLE is ignored; it is not queued and the frame register is unchanged.
//  If wr_ps2_i is asserted in the same cycle that WREL returns to IDLE, it is ignored.
//   A new request must come while tx_idle_o=1.
//  Only one of tx_done_tick_o and err_tick_o can pulse per frame. Both are never high together.
//  ps2c_oe_o and ps2d_oe_o are never 1 outside RTS/REQ/DATA.
// TESTING
//  1. din=0xED, the device model clocks at 12.5 kHz and ACKs.
//     -> ps2c held low for 5000 cycles; ps2d bits seen at device rising edges: 0,1,0,1,1,0,1,1,1,P=1,stop=1.
//     -> exactly one tx_done_tick_o, and tx_idle_o returns to 1.
//  2. din=0x00 -> parity bit 1; din=0xFF -> parity bit 1; din=0x01 -> parity bit 0. All complete with ACK.
//  3. The device model does not drive ACK (ps2d stays high at fall 11).
//     -> one err_tick_o, no tx_done_tick_o, state returns to IDLE.
//  4. The device stops clocking after 4 falls.
//     -> after TIMEOUT_CYCLES: err_tick_o pulse, both oe=0, tx_idle_o=1.
//  5. A second wr_ps2_i with din=0xAA during DATA -> ignored; the 0xED frame completes unchanged.
//  6. rst_i during DATA at fall 5 -> next cycle both oe=0 and tx_idle_o=1, no ticks.
//     A subsequent send of 0xF4 completes normally.
//  7. 1-3 cycle low glitches injected on ps2c_i during DATA -> no extra shifts; frame bits remain correct.

Source files
------------

// File: rtl/ps2_host_tx.sv
// -----------------------------------------------------------------------------
// ps2_host_tx
// PS/2 host-to-device transmitter. It sends one command byte (for example 0xED
// set-LEDs or 0xFF reset) to the keyboard over the shared open-drain ps2c/ps2d
// lines. This block can only pull a line low, through its *_oe_o enables. The
// pad releases the line when the enable is 0. While a frame is in progress,
// tx_idle_o is low so the keyboard receive path can ignore the bus traffic.
//
// Ports
//   clk_i           system clock
//   rst_i           synchronous reset, active-high
//   wr_ps2_i        1-cycle strobe that starts a transmission (accepted only in IDLE)
//   din_i[7:0]      command byte, sampled when the strobe is accepted
//   ps2c_i          PS/2 clock line as read back from the pad
//   ps2d_i          PS/2 data line as read back from the pad
//   ps2c_oe_o       1 = pull ps2c low (registered)
//   ps2d_oe_o       1 = pull ps2d low (registered)
//   tx_idle_o       1 = FSM in IDLE (registered)
//   tx_done_tick_o  1-cycle pulse: frame ended with a valid device ACK
//   err_tick_o      1-cycle pulse: frame aborted (no ACK or timeout)
// -----------------------------------------------------------------------------
module ps2_host_tx #(
    parameter int INHIBIT_CYCLES = 5000,
    parameter int FILTER_LEN     = 8,
    parameter int TIMEOUT_CYCLES = 1_000_000
) (
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic       wr_ps2_i,
    input  logic [7:0] din_i,
    input  logic       ps2c_i,
    input  logic       ps2d_i,
    output logic       ps2c_oe_o,
    output logic       ps2d_oe_o,
    output logic       tx_idle_o,
    output logic       tx_done_tick_o,
    output logic       err_tick_o
);

    // One counter serves as the inhibit timer in RTS and as the
    // device-clock timeout in DATA/ACK/WREL, so size it for the larger use.
    localparam int CNT_MAX = (INHIBIT_CYCLES > TIMEOUT_CYCLES) ? INHIBIT_CYCLES : TIMEOUT_CYCLES;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);
    localparam logic [CNT_W-1:0] INHIBIT_LAST  = CNT_W'(INHIBIT_CYCLES - 1);
    localparam logic [CNT_W-1:0] TIMEOUT_LIMIT = CNT_W'(TIMEOUT_CYCLES);

    typedef enum logic [2:0] {
        IDLE,
        RTS,
        REQ,
        DATA,
        ACK,
        WREL
    } state_e;

    state_e                  state_q,     state_d;
    logic [FILTER_LEN-1:0]   filt_sr_q,   filt_sr_d;
    logic                    filt_q,      filt_d;
    logic                    filt_prev_q, filt_prev_d;
    logic [8:0]              frame_q,     frame_d;
    logic [3:0]              bit_cnt_q,   bit_cnt_d;
    logic [CNT_W-1:0]        cnt_q,       cnt_d;
    logic                    ack_ok_q,    ack_ok_d;
    logic                    ps2c_oe_q,   ps2c_oe_d;
    logic                    ps2d_oe_q,   ps2d_oe_d;
    logic                    tx_idle_q,   tx_idle_d;
    logic                    done_tick_q, done_tick_d;
    logic                    err_tick_q,  err_tick_d;
    logic                    fall;

    // -------------------------------------------------------------------------
    // ps2c glitch filter. The filtered clock changes only after FILTER_LEN
    // identical samples, so short spikes cannot produce a false fall.
    // -------------------------------------------------------------------------
    always_comb begin
        filt_sr_d   = {filt_sr_q[FILTER_LEN-2:0], ps2c_i};
        filt_prev_d = filt_q;
        filt_d      = filt_q;
        if (&filt_sr_q) begin
            filt_d = 1'b1;
        end else if (~|filt_sr_q) begin
            filt_d = 1'b0;
        end
    end

    assign fall = filt_prev_q & ~filt_q;

    // -------------------------------------------------------------------------
    // Next-state logic. The registered outputs are derived from state_d, so
    // each output flop lines up with the state it belongs to.
    // -------------------------------------------------------------------------
    always_comb begin
        // NOTE: every signal gets a default before the case; otherwise any path that skips an assignment infers a latch.
        state_d     = state_q;
        frame_d     = frame_q;
        bit_cnt_d   = bit_cnt_q;
        cnt_d       = cnt_q;
        ack_ok_d    = ack_ok_q;
        ps2d_oe_d   = ps2d_oe_q;
        done_tick_d = 1'b0;
        err_tick_d  = 1'b0;

        case (state_q)
            IDLE: begin
                ps2d_oe_d = 1'b0;
                if (wr_ps2_i) begin
                    frame_d = {~^din_i, din_i};
                    cnt_d   = '0;
                    state_d = RTS;
                end
            end

            RTS: begin
                if (cnt_q == INHIBIT_LAST) begin
                    ps2d_oe_d = 1'b1;
                    state_d   = REQ;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end

            // ps2c is released when the FSM leaves REQ. ps2d stays low as the start bit.
            REQ: begin
                cnt_d     = '0;
                bit_cnt_d = '0;
                state_d   = DATA;
            end

            DATA: begin
                if (fall) begin
                    cnt_d = '0;
                    if (bit_cnt_q == 4'd9) begin
                        ps2d_oe_d = 1'b0;          // stop bit: release data
                        state_d   = ACK;
                    end else begin
                        ps2d_oe_d = ~frame_q[0];
                        frame_d   = {1'b0, frame_q[8:1]};
                        bit_cnt_d = bit_cnt_q + 4'd1;
                    end
                end else if (cnt_q == TIMEOUT_LIMIT) begin
                    ps2d_oe_d  = 1'b0;
                    err_tick_d = 1'b1;
                    state_d    = IDLE;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end

            ACK: begin
                if (fall) begin
                    cnt_d    = '0;
                    ack_ok_d = ~ps2d_i;
                    state_d  = WREL;
                end else if (cnt_q == TIMEOUT_LIMIT) begin
                    err_tick_d = 1'b1;
                    state_d    = IDLE;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end

            // Wait for the device to release both lines before ending the frame.
            WREL: begin
                if (filt_q && ps2d_i) begin
                    done_tick_d = ack_ok_q;
                    err_tick_d  = ~ack_ok_q;
                    state_d     = IDLE;
                end else if (fall) begin
                    cnt_d = '0;
                end else if (cnt_q == TIMEOUT_LIMIT) begin
                    err_tick_d = 1'b1;
                    state_d    = IDLE;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end

            default: begin
                ps2d_oe_d = 1'b0;
                state_d   = IDLE;
            end
        endcase

        ps2c_oe_d = (state_d == RTS) || (state_d == REQ);
        tx_idle_d = (state_d == IDLE);
    end

    // -------------------------------------------------------------------------
    // Registers
    // -------------------------------------------------------------------------
    always_ff @(posedge clk_i) begin
        // NOTE: sequential state uses non-blocking assignments so that every flop samples its pre-edge inputs.
        if (rst_i) begin
            state_q     <= IDLE;
            filt_sr_q   <= '1;
            filt_q      <= 1'b1;
            filt_prev_q <= 1'b1;
            frame_q     <= '0;
            bit_cnt_q   <= '0;
            cnt_q       <= '0;
            ack_ok_q    <= 1'b0;
            ps2c_oe_q   <= 1'b0;
            ps2d_oe_q   <= 1'b0;
            tx_idle_q   <= 1'b1;
            done_tick_q <= 1'b0;
            err_tick_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            filt_sr_q   <= filt_sr_d;
            filt_q      <= filt_d;
            filt_prev_q <= filt_prev_d;
            frame_q     <= frame_d;
            bit_cnt_q   <= bit_cnt_d;
            cnt_q       <= cnt_d;
            ack_ok_q    <= ack_ok_d;
            ps2c_oe_q   <= ps2c_oe_d;
            ps2d_oe_q   <= ps2d_oe_d;
            tx_idle_q   <= tx_idle_d;
            done_tick_q <= done_tick_d;
            err_tick_q  <= err_tick_d;
        end
    end

    assign ps2c_oe_o      = ps2c_oe_q;
    assign ps2d_oe_o      = ps2d_oe_q;
    assign tx_idle_o      = tx_idle_q;
    assign tx_done_tick_o = done_tick_q;
    assign err_tick_o     = err_tick_q;

endmodule
